// File: rtl/bomb_pkg.sv
// Shared types and helpers for the bomb subsystem.
// Used by the dispatcher, player and map blocks.
package bomb_pkg;

  localparam int TILE_SHIFT_DEFAULT = 5;

  typedef logic signed [10:0] coord_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECIDE,
    S_ISSUE,
    S_WAIT_ACK
  } disp_state_t;

  // Round to the nearest tile corner; the 11-bit wrap is intentional.
  function automatic coord_t snap_coord(
    input coord_t v,
    input int     sh
  );
    logic [10:0] t;
    if (v < 0) return '0;
    t = v + (11'd1 << (sh - 1));
    t = (t >> sh) << sh;
    return t;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter; the pointer moves past the winner
// whenever the advance strobe is raised with a request present.
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);

  logic [W-1:0] ptr_q, ptr_d;
  logic         found;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    grant = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr_q) + i) % N]) begin
        found = 1'b1;
        idx   = W'((int'(ptr_q) + i) % N);
      end
    end
    if (found) grant[idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) ptr_d = W'((int'(idx) + 1) % N);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bomb_dispatcher.sv
// Hands out bomb_fsm slots to players: snaps positions to tiles,
// enforces per-player limits and one bomb per tile.
module bomb_dispatcher
  import bomb_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int NUM_PLAYERS    = 2,
  parameter int MAX_PER_PLAYER = 2,
  parameter int TILE_SHIFT     = TILE_SHIFT_DEFAULT,
  parameter int ACK_TIMEOUT    = 4
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic   [NUM_PLAYERS-1:0]      place_req,
  input  coord_t [NUM_PLAYERS-1:0]      player_x,
  input  coord_t [NUM_PLAYERS-1:0]      player_y,
  input  logic   [NUM_SLOTS-1:0]        slot_exist,
  input  logic   [NUM_SLOTS-1:0]        slot_exploded,
  output logic   [NUM_SLOTS-1:0]        slot_init,
  output coord_t [NUM_SLOTS-1:0]        slot_x,
  output coord_t [NUM_SLOTS-1:0]        slot_y,
  output logic   [NUM_PLAYERS-1:0]      place_ack,
  output logic   [NUM_PLAYERS-1:0]      place_nack,
  output logic   [NUM_PLAYERS-1:0][1:0] live_count,
  output logic                          slot_fault
);

  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef logic [PW-1:0] pid_t;
  typedef logic [SW-1:0] sid_t;

  disp_state_t                 state_q, state_d;
  logic   [NUM_PLAYERS-1:0]    pending_q, pending_d;
  coord_t [NUM_PLAYERS-1:0]    req_x_q, req_x_d;
  coord_t [NUM_PLAYERS-1:0]    req_y_q, req_y_d;
  logic   [NUM_SLOTS-1:0]      reserved_q, reserved_d;
  logic   [NUM_SLOTS-1:0]      exploded_q;
  pid_t   [NUM_SLOTS-1:0]      owner_q, owner_d;
  coord_t [NUM_SLOTS-1:0]      slot_x_q, slot_x_d;
  coord_t [NUM_SLOTS-1:0]      slot_y_q, slot_y_d;
  logic [NUM_PLAYERS-1:0][1:0] count_q, count_d;
  sid_t                        cur_slot_q, cur_slot_d;
  pid_t                        cur_player_q, cur_player_d;
  logic [TW-1:0]               timer_q, timer_d;
  logic                        fault_q, fault_d;

  logic [NUM_PLAYERS-1:0] rr_grant;
  pid_t                   rr_idx;
  logic                   rr_adv;
  logic [NUM_SLOTS-1:0]   grant_mask;
  logic [NUM_SLOTS-1:0]   fault_clr;
  logic [NUM_SLOTS-1:0]   clr;
  logic [NUM_PLAYERS-1:0] inc;
  logic                   free_found;
  logic                   dup_hit;
  sid_t                   free_idx;

  assign rr_adv = (state_q == S_DECIDE);

  rr_arbiter #(
    .N (NUM_PLAYERS),
    .W (PW)
  ) u_rr (
    .clk     (clk),
    .resetN  (resetN),
    .req     (pending_q),
    .advance (rr_adv),
    .grant   (rr_grant),
    .idx     (rr_idx)
  );

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    dup_hit    = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (!reserved_q[s] && !free_found) begin
        free_found = 1'b1;
        free_idx   = sid_t'(s);
      end
      if (reserved_q[s] &&
          slot_x_q[s] == req_x_q[rr_idx] &&
          slot_y_q[s] == req_y_q[rr_idx])
        dup_hit = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    req_x_d      = req_x_q;
    req_y_d      = req_y_q;
    owner_d      = owner_q;
    slot_x_d     = slot_x_q;
    slot_y_d     = slot_y_q;
    cur_slot_d   = cur_slot_q;
    cur_player_d = cur_player_q;
    timer_d      = timer_q;
    fault_d      = fault_q;
    grant_mask   = '0;
    fault_clr    = '0;
    inc          = '0;
    slot_init    = '0;
    place_ack    = '0;
    place_nack   = '0;

    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (place_req[p] && !pending_q[p]) begin
        pending_d[p] = 1'b1;
        req_x_d[p]   = snap_coord(player_x[p], TILE_SHIFT);
        req_y_d[p]   = snap_coord(player_y[p], TILE_SHIFT);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (|pending_d) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        pending_d = pending_d & ~rr_grant;
        if (int'(count_q[rr_idx]) >= MAX_PER_PLAYER ||
            !free_found || dup_hit) begin
          place_nack = rr_grant;
          state_d    = S_IDLE;
        end else begin
          grant_mask[free_idx] = 1'b1;
          inc                  = rr_grant;
          owner_d[free_idx]    = rr_idx;
          slot_x_d[free_idx]   = req_x_q[rr_idx];
          slot_y_d[free_idx]   = req_y_q[rr_idx];
          cur_slot_d           = free_idx;
          cur_player_d         = rr_idx;
          state_d              = S_ISSUE;
        end
      end
      S_ISSUE: begin
        slot_init[cur_slot_q]   = 1'b1;
        place_ack[cur_player_q] = 1'b1;
        timer_d                 = '0;
        state_d                 = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (slot_exist[cur_slot_q]) begin
          state_d = S_IDLE;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          fault_clr[cur_slot_q] = 1'b1;
          fault_d               = 1'b1;
          state_d               = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A slot freed by both a release and a timeout is counted once.
  always_comb begin
    int n;
    n          = 0;
    clr        = (exploded_q & ~slot_exploded & reserved_q) | fault_clr;
    reserved_d = (reserved_q & ~clr) | grant_mask;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      n = int'(count_q[p]) + (inc[p] ? 1 : 0);
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (clr[s] && owner_q[s] == pid_t'(p)) n = n - 1;
      end
      if (n < 0) n = 0;
      if (n > MAX_PER_PLAYER) n = MAX_PER_PLAYER;
      count_d[p] = 2'(n);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      req_x_q      <= '0;
      req_y_q      <= '0;
      reserved_q   <= '0;
      exploded_q   <= '0;
      owner_q      <= '0;
      slot_x_q     <= '0;
      slot_y_q     <= '0;
      count_q      <= '0;
      cur_slot_q   <= '0;
      cur_player_q <= '0;
      timer_q      <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      req_x_q      <= req_x_d;
      req_y_q      <= req_y_d;
      reserved_q   <= reserved_d;
      exploded_q   <= slot_exploded;
      owner_q      <= owner_d;
      slot_x_q     <= slot_x_d;
      slot_y_q     <= slot_y_d;
      count_q      <= count_d;
      cur_slot_q   <= cur_slot_d;
      cur_player_q <= cur_player_d;
      timer_q      <= timer_d;
      fault_q      <= fault_d;
    end
  end

  assign slot_x     = slot_x_q;
  assign slot_y     = slot_y_q;
  assign live_count = count_q;
  assign slot_fault = fault_q;

endmodule

// File: tb/tb_bomb_dispatcher.sv
// Directed + random bench for bomb_dispatcher with a
// transaction-level slot-pool reference model.
module tb_bomb_dispatcher;
  import bomb_pkg::*;

  localparam int NS = 4;
  localparam int NP = 2;

  logic                 clk = 1'b0;
  logic                 resetN = 1'b0;
  logic [NP-1:0]        place_req = '0;
  coord_t [NP-1:0]      player_x = '0;
  coord_t [NP-1:0]      player_y = '0;
  logic [NS-1:0]        slot_exist = '0;
  logic [NS-1:0]        slot_exploded = '0;
  logic [NS-1:0]        slot_init;
  coord_t [NS-1:0]      slot_x;
  coord_t [NS-1:0]      slot_y;
  logic [NP-1:0]        place_ack;
  logic [NP-1:0]        place_nack;
  logic [NP-1:0][1:0]   live_count;
  logic                 slot_fault;

  bomb_dispatcher dut (
    .clk           (clk),
    .resetN        (resetN),
    .place_req     (place_req),
    .player_x      (player_x),
    .player_y      (player_y),
    .slot_exist    (slot_exist),
    .slot_exploded (slot_exploded),
    .slot_init     (slot_init),
    .slot_x        (slot_x),
    .slot_y        (slot_y),
    .place_ack     (place_ack),
    .place_nack    (place_nack),
    .live_count    (live_count),
    .slot_fault    (slot_fault)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  int m_res [NS];
  int m_own [NS];
  int m_sx  [NS];
  int m_sy  [NS];
  int m_cnt [NP];
  int m_pend[NP];
  int m_px  [NP];
  int m_py  [NP];
  int m_ptr;
  int m_fault;
  int pend_rel;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] req_v);
    ncmp++;
    assert (obs === req_v) else begin
      nfail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, req_v);
    end
  endtask

  function automatic int snap(input int x);
    coord_t c;
    int v;
    c = 11'(x);
    v = int'(c);
    if (v < 0) return 0;
    return (((v + 16) / 32) * 32) % 2048;
  endfunction

  function automatic logic [31:0] cnt_vec();
    return {28'b0, 2'(m_cnt[1]), 2'(m_cnt[0])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_res[i] = 0; m_own[i] = 0; m_sx[i] = 0; m_sy[i] = 0;
    end
    for (int p = 0; p < NP; p++) begin
      m_cnt[p] = 0; m_pend[p] = 0; m_px[p] = 0; m_py[p] = 0;
    end
    m_ptr = 0;
    m_fault = 0;
    pend_rel = -1;
  endtask

  task automatic model_release(input int s);
    if (m_res[s] != 0) begin
      m_res[s] = 0;
      if (m_cnt[m_own[s]] > 0) m_cnt[m_own[s]]--;
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_init"}, {28'b0, slot_init}, 0);
    chk({tag, "_ack"}, {30'b0, place_ack}, 0);
    chk({tag, "_nack"}, {30'b0, place_nack}, 0);
    chk({tag, "_count"}, {28'b0, live_count}, 0);
    chk({tag, "_fault"}, {31'b0, slot_fault}, 0);
    chk({tag, "_sx"}, {21'b0, slot_x[0]} | {21'b0, slot_x[3]}, 0);
    chk({tag, "_sy"}, {21'b0, slot_y[1]} | {21'b0, slot_y[2]}, 0);
  endtask

  task automatic do_release(input int s);
    slot_exploded[s] = 1'b1;
    step();
    slot_exploded[s] = 1'b0;
    slot_exist[s] = 1'b0;
    step();
    model_release(s);
    chk("count_release", {28'b0, live_count}, cnt_vec());
  endtask

  task automatic serve(input int p, input bit ack_ok, input bit first);
    int s;
    int w;
    bit dup;
    bit deny;
    s = -1;
    dup = 0;
    for (int i = 0; i < NS; i++) begin
      if (m_res[i] == 0 && s < 0) s = i;
      if (m_res[i] != 0 && m_sx[i] == m_px[p] && m_sy[i] == m_py[p]) dup = 1;
    end
    deny = (m_cnt[p] >= 2) || (s < 0) || dup;
    m_pend[p] = 0;
    m_ptr = (p + 1) % NP;
    w = 0;
    while (place_nack == '0 && slot_init == '0 && w < 12) begin
      step();
      w++;
    end
    if (first) chk("decide_latency", w, deny ? 0 : 1);
    else       chk("decide_bound", {31'b0, w < 12}, 1);
    if (first && pend_rel >= 0) begin
      model_release(pend_rel);
      pend_rel = -1;
    end
    if (deny) begin
      chk("nack", {30'b0, place_nack}, 1 << p);
      chk("nack_no_init", {28'b0, slot_init}, 0);
      step();
      chk("count_after_nack", {28'b0, live_count}, cnt_vec());
    end else begin
      m_res[s] = 1; m_own[s] = p;
      m_sx[s] = m_px[p]; m_sy[s] = m_py[p];
      m_cnt[p]++;
      chk("init", {28'b0, slot_init}, 1 << s);
      chk("ack", {30'b0, place_ack}, 1 << p);
      chk("no_nack", {30'b0, place_nack}, 0);
      chk("slot_x", {21'b0, slot_x[s]}, m_sx[s]);
      chk("slot_y", {21'b0, slot_y[s]}, m_sy[s]);
      chk("count_grant", {28'b0, live_count}, cnt_vec());
      step();
      chk("init_pulse", {28'b0, slot_init}, 0);
      chk("ack_pulse", {30'b0, place_ack}, 0);
      if (ack_ok) begin
        step();
        slot_exist[s] = 1'b1;
        step();
        chk("slot_x_hold", {21'b0, slot_x[s]}, m_sx[s]);
      end else begin
        step(); step(); step();
        chk("fault_early", {31'b0, slot_fault}, m_fault);
        step();
        m_fault = 1;
        m_res[s] = 0;
        m_cnt[p]--;
        chk("fault", {31'b0, slot_fault}, 1);
        chk("count_fault", {28'b0, live_count}, cnt_vec());
      end
    end
  endtask

  task automatic do_request(input int mask, input int x0, input int y0,
                            input int x1, input int y1,
                            input bit ack_ok, input int rel);
    bit first;
    int p;
    pend_rel = rel;
    if (mask[0]) begin m_pend[0] = 1; m_px[0] = snap(x0); m_py[0] = snap(y0); end
    if (mask[1]) begin m_pend[1] = 1; m_px[1] = snap(x1); m_py[1] = snap(y1); end
    place_req = 2'(mask);
    player_x[0] = 11'(x0); player_y[0] = 11'(y0);
    player_x[1] = 11'(x1); player_y[1] = 11'(y1);
    if (rel >= 0) slot_exploded[rel] = 1'b1;
    step();
    place_req = '0;
    player_x[0] = 11'($urandom); player_y[0] = 11'($urandom);
    player_x[1] = 11'($urandom); player_y[1] = 11'($urandom);
    if (rel >= 0) begin
      slot_exploded[rel] = 1'b0;
      slot_exist[rel] = 1'b0;
    end
    first = 1;
    while (m_pend[0] != 0 || m_pend[1] != 0) begin
      p = (m_pend[m_ptr] != 0) ? m_ptr : 1 - m_ptr;
      serve(p, ack_ok, first);
      first = 0;
    end
  endtask

  function automatic int rnd_coord(input int s);
    if (m_res[s] != 0 && $urandom_range(0, 1) == 1)
      return m_sx[s] + int'($urandom_range(0, 15));
    return int'($urandom_range(0, 1073)) - 50;
  endfunction

  initial begin
    int xs [NP];
    int ys [NP];
    int rel;
    model_reset();
    repeat (2) step();
    chk_idle_outputs("reset");
    resetN = 1'b1;

    do_request(1, 45, 70, 0, 0, 1, -1);
    chk("grant_tile_x", {21'b0, slot_x[0]}, 32);
    chk("grant_tile_y", {21'b0, slot_y[0]}, 64);
    do_request(2, 0, 0, 40, 66, 1, -1);
    do_request(1, 200, 100, 0, 0, 1, -1);
    do_request(1, 400, 300, 0, 0, 1, -1);
    do_release(0);
    do_request(1, 500, 20, 0, 0, 1, -1);
    do_request(2, 0, 0, 600, 600, 1, -1);
    do_release(0);
    do_release(1);
    do_release(2);
    do_request(3, 100, 100, 300, 300, 1, -1);
    do_request(3, 700, 100, 700, 300, 1, -1);
    do_release(3);
    do_request(2, 0, 0, 800, 500, 1, 1);
    do_release(0);
    do_request(1, 50, 400, 0, 0, 0, -1);
    do_request(1, -20, 1023, 0, 0, 1, -1);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) < 3) begin
        do_release(int'($urandom_range(0, NS - 1)));
      end else begin
        for (int p = 0; p < NP; p++) begin
          xs[p] = rnd_coord(int'($urandom_range(0, NS - 1)));
          ys[p] = int'($urandom_range(0, 1073)) - 50;
          for (int s = 0; s < NS; s++)
            if (m_res[s] != 0 && m_sx[s] == snap(xs[p]) && $urandom_range(0, 1) == 1)
              ys[p] = m_sy[s] + int'($urandom_range(0, 15));
        end
        rel = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NS - 1)) : -1;
        do_request(int'($urandom_range(1, 3)), xs[0], ys[0], xs[1], ys[1],
                   $urandom_range(0, 7) != 0, rel);
      end
    end

    place_req = 2'b01;
    player_x[0] = 11'd64; player_y[0] = 11'd64;
    step();
    place_req = '0;
    step();
    #2;
    resetN = 1'b0;
    slot_exist = '0;
    slot_exploded = '0;
    #1;
    chk_idle_outputs("midreset");
    step();
    resetN = 1'b1;
    model_reset();
    do_request(1, 64, 64, 0, 0, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
